// File: rtl/calc_pkg.sv
// Shared calculator definitions: BCD converter state encoding, BCD digit
// geometry and correction constants, and the special digit codes the
// seven-segment driver uses for minus sign and blank.
package calc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } bcd_state_e;

  localparam int unsigned BCD_DIGIT_W = 4;

  // Double-dabble correction: a digit of 5 or more gets +3 before the shift
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_MIN = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD = 4'd3;

  // Non-numeric digit codes understood by the display driver
  localparam logic [BCD_DIGIT_W-1:0] BCD_CODE_MINUS = 4'd14;
  localparam logic [BCD_DIGIT_W-1:0] BCD_CODE_BLANK = 4'd15;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit corrector.
// Ports:
//   d_i : BCD digit before correction
//   d_o : d_i + 3 when d_i >= 5, otherwise d_i unchanged
module bcd_add3
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_ADJ_MIN) begin
      d_o = d_i + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bcd_convert.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Ports:
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   start     : conversion request, sampled only in IDLE
//   signed_en : din is two's complement when 1 (sampled with start)
//   din       : WIDTH-bit value to convert (sampled with start)
//   busy      : high while a conversion is in progress
//   done      : one-cycle pulse; bcd/neg update in the same cycle
//   neg       : result sign
//   bcd       : packed digits, [3:0] ones, [7:4] tens, [11:8] hundreds
module bcd_convert
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          signed_en,
  input  logic [WIDTH-1:0]              din,
  output logic                          busy,
  output logic                          done,
  output logic                          neg,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  bcd_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_adj;
  logic              sign_q;
  logic              busy_q, done_q, neg_q;
  logic [ACC_W-1:0]  bcd_q;

  logic [WIDTH-1:0]       mag;
  logic                   sign_in;
  logic [ACC_W+WIDTH-1:0] pair_sh;

  // Per-digit add-3 correction applied before every shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .d_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    sign_in = signed_en & din[WIDTH-1];
    // Negation kept WIDTH bits wide so the most negative value reads as
    // its unsigned magnitude (e.g. -128 -> 128)
    mag     = sign_in ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;
    pair_sh = {acc_adj, bin_q} << 1;
    acc_d   = pair_sh[ACC_W+WIDTH-1:WIDTH];
    bin_d   = pair_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q   <= mag;
            acc_q   <= '0;
            sign_q  <= sign_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            // Final shift result goes straight to the output register
            bcd_q   <= acc_d;
            neg_q   <= sign_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign neg  = neg_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_convert.sv
// Self-checking bench for bcd_convert: directed vector table, hand-written
// multi-cycle sequences, random and exhaustive sweeps against an
// arithmetic reference model.
module tb_bcd_convert;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_en;
  logic [7:0]  din;
  logic        busy;
  logic        done;
  logic        neg;
  logic [11:0] bcd;

  int unsigned n_chk;
  int unsigned n_fail;

  logic [11:0] prev_bcd;
  logic        prev_neg;

  bcd_convert #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_en (signed_en),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .neg       (neg),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic        sgn;
    logic [11:0] bcd;
    logic        neg;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits of the magnitude via plain arithmetic
  function automatic logic [12:0] model(input logic [7:0] d, input logic s);
    int unsigned m;
    logic        n;
    logic [3:0]  h, t, o;
    n = s && (d >= 8'd128);
    m = n ? (256 - int'(d)) : int'(d);
    h = 4'(m / 100);
    t = 4'((m / 10) % 10);
    o = 4'(m % 10);
    return {n, h, t, o};
  endfunction

  // Called #1 after a rising edge with the DUT idle. Checks busy/done/bcd
  // every cycle of the conversion and the result exactly 8 cycles later.
  task automatic run_conv(input logic [7:0] d, input logic s,
                          input logic [11:0] eb, input logic en, input string tag);
    start = 1'b1; din = d; signed_en = s;
    @(posedge clk); #1;
    start = 1'b0;
    din = $urandom; signed_en = $urandom;
    chk({tag, "_accept"}, {busy, done, neg, bcd}, {1'b1, 1'b0, prev_neg, prev_bcd});
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i < 8)
        chk({tag, "_mid"}, {busy, done, neg, bcd}, {1'b1, 1'b0, prev_neg, prev_bcd});
      else
        chk({tag, "_done"}, {busy, done, neg, bcd}, {1'b0, 1'b1, en, eb});
    end
    prev_bcd = eb;
    prev_neg = en;
  endtask

  task automatic idle_no_done(input int unsigned cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < int'(cycles); i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk({tag, "_quiet"}, {31'd0, seen}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [12:0] m;
    logic [7:0]  d;
    logic        s;

    n_chk = 0; n_fail = 0;
    prev_bcd = '0; prev_neg = 1'b0;

    vecs[0] = '{8'hFF, 1'b0, 12'h255, 1'b0};
    vecs[1] = '{8'h80, 1'b1, 12'h128, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 12'h001, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 12'h000, 1'b0};
    vecs[4] = '{8'h7F, 1'b1, 12'h127, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 12'h128, 1'b0};
    vecs[6] = '{8'h0A, 1'b0, 12'h010, 1'b0};
    vecs[7] = '{8'h64, 1'b0, 12'h100, 1'b0};
    vecs[8] = '{8'h63, 1'b0, 12'h099, 1'b0};
    vecs[9] = '{8'h9C, 1'b1, 12'h100, 1'b1};

    rst = 1'b1; start = 1'b0; signed_en = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, neg, bcd}, 32'd0);
    rst = 1'b0;
    idle_no_done(12, "reset_idle");
    chk("idle_outputs", {busy, done, neg, bcd}, 32'd0);

    // Directed table, applied back to back (start on each done cycle)
    foreach (vecs[i])
      run_conv(vecs[i].din, vecs[i].sgn, vecs[i].bcd, vecs[i].neg, $sformatf("vec%0d", i));
    idle_no_done(10, "after_table");
    chk("hold_after_table", {neg, bcd}, {prev_neg, prev_bcd});

    // Start pulsed mid-conversion of 42 is ignored, not queued
    start = 1'b1; din = 8'd42; signed_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin start = 1'b1; din = 8'd99; end
      if (i == 4) start = 1'b0;
      @(posedge clk); #1;
      if (i < 8)
        chk("ign_mid", {busy, done, neg, bcd}, {1'b1, 1'b0, prev_neg, prev_bcd});
      else
        chk("ign_done", {busy, done, neg, bcd}, {1'b0, 1'b1, 1'b0, 12'h042});
    end
    prev_bcd = 12'h042; prev_neg = 1'b0;
    // New start on the done cycle: 7 comes out 8 cycles later
    run_conv(8'd7, 1'b0, 12'h007, 1'b0, "on_done");
    idle_no_done(10, "after_ignore");

    // Reset 4 cycles into converting 99 aborts with no done
    start = 1'b1; din = 8'd99; signed_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy", {busy, done}, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_outputs", {busy, done, neg, bcd}, 32'd0);
    prev_bcd = '0; prev_neg = 1'b0;
    idle_no_done(12, "abort");
    run_conv(8'd99, 1'b0, 12'h099, 1'b0, "after_abort");

    // rst and start together: request dropped
    rst = 1'b1; start = 1'b1; din = 8'd55;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_outputs", {busy, done, neg, bcd}, 32'd0);
    prev_bcd = '0; prev_neg = 1'b0;
    idle_no_done(12, "rst_start");

    // Random conversions against the reference model
    for (int i = 0; i < 64; i++) begin
      d = 8'($urandom);
      s = 1'($urandom);
      m = model(d, s);
      run_conv(d, s, m[11:0], m[12], "rand");
      if ($urandom_range(3) == 0) idle_no_done($urandom_range(1, 4), "rand_gap");
    end

    // Exhaustive sweep in both modes
    for (int mode = 0; mode < 2; mode++) begin
      for (int v = 0; v < 256; v++) begin
        d = 8'(v);
        s = 1'(mode);
        m = model(d, s);
        run_conv(d, s, m[11:0], m[12], mode == 0 ? "sweep_u" : "sweep_s");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
